// File: rtl/bidir_xfer_pkg.sv
// Shared types and constants for the bidirectional transfer front-end.
// The optional completion counters are enabled by defining BIDIR_XFER_STATS_EN.
package bidir_xfer_pkg;

    localparam int   DEF_DATA_W = 8;

    // Value of bus_dir: controller drives, or device drives
    localparam logic DIR_CTRL   = 1'b1;
    localparam logic DIR_DEV    = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        WRITE,
        CAPTURE,
        RESP
    } xfer_state_e;

    // 16-bit increment that holds at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bidir_ta_timer.sv
// Turnaround timer: loaded when a direction change is accepted, counts
// down once per cycle and flags done on the last turnaround cycle.
module bidir_ta_timer #(
    parameter int TA_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    localparam int            CW       = $clog2(TA_CYCLES + 1);
    // The first turnaround cycle already sees the loaded value, so load N-1
    localparam logic [CW-1:0] LOAD_VAL = CW'(TA_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on request, otherwise step towards zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bidir_xfer_ctrl.sv
// Request/response front-end for a bidirectional data bus. Inserts
// turnaround idle cycles on every change of bus ownership, drives write
// data and captures read data. Define BIDIR_XFER_STATS_EN to build the
// saturating write/read completion counters; otherwise they read 0.
module bidir_xfer_ctrl
    import bidir_xfer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TA_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_dir,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    xfer_state_e       state_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_dir_q;
    logic              oe_q;
    logic              dir_q;
    logic [DATA_W-1:0] data_o_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              accept;
    logic              need_turn;
    logic              ta_done;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign need_turn = (req_write != last_dir_q);

    bidir_ta_timer #(
        .TA_CYCLES (TA_CYCLES)
    ) u_ta_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept && need_turn),
        .done_o (ta_done)
    );

    // Transfer state machine with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            last_dir_q  <= DIR_DEV;
            oe_q        <= 1'b0;
            dir_q       <= DIR_DEV;
            data_o_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        if (need_turn) begin
                            // Release the bus and flip direction for the turnaround
                            state_q <= TURN;
                            oe_q    <= 1'b0;
                            dir_q   <= req_write;
                        end else if (req_write) begin
                            state_q  <= WRITE;
                            oe_q     <= 1'b1;
                            dir_q    <= DIR_CTRL;
                            data_o_q <= req_wdata;
                        end else begin
                            state_q <= CAPTURE;
                            oe_q    <= 1'b0;
                            dir_q   <= DIR_DEV;
                        end
                    end
                end
                TURN: begin
                    if (ta_done) begin
                        last_dir_q <= write_q;
                        if (write_q) begin
                            state_q  <= WRITE;
                            oe_q     <= 1'b1;
                            data_o_q <= wdata_q;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                WRITE: begin
                    // Stop driving but keep ownership until the next direction change
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                end
                CAPTURE: begin
                    state_q     <= RESP;
                    rsp_rdata_q <= bus_data_i;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_data_oe = oe_q;
    assign bus_dir     = dir_q;
    assign bus_data_o  = data_o_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

`ifdef BIDIR_XFER_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    // Saturating counts of completed writes and handed-off reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (state_q == WRITE) begin
                wr_cnt_q <= sat_inc16(wr_cnt_q);
            end
            if ((state_q == RESP) && rsp_ready) begin
                rd_cnt_q <= sat_inc16(rd_cnt_q);
            end
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_bidir_xfer_ctrl.sv
// Directed bench for bidir_xfer_ctrl: instance 0 uses one turnaround
// cycle, instance 1 uses two. Write data and read data flow through
// expectation queues filled when a request is issued.
module tb_bidir_xfer_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid   [2];
    logic          req_write   [2];
    logic [DW-1:0] req_wdata   [2];
    logic          rsp_ready   [2];
    logic [DW-1:0] bus_data_i  [2];
    logic          req_ready   [2];
    logic          rsp_valid   [2];
    logic [DW-1:0] rsp_rdata   [2];
    logic [DW-1:0] bus_data_o  [2];
    logic          bus_data_oe [2];
    logic          bus_dir     [2];
    logic [15:0]   wr_count    [2];
    logic [15:0]   rd_count    [2];

    bidir_xfer_ctrl #(.DATA_W(DW), .TA_CYCLES(1)) u_ta1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .bus_data_o(bus_data_o[0]), .bus_data_oe(bus_data_oe[0]),
        .bus_data_i(bus_data_i[0]), .bus_dir(bus_dir[0]),
        .wr_count(wr_count[0]), .rd_count(rd_count[0])
    );

    bidir_xfer_ctrl #(.DATA_W(DW), .TA_CYCLES(2)) u_ta2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .bus_data_o(bus_data_o[1]), .bus_data_oe(bus_data_oe[1]),
        .bus_data_i(bus_data_i[1]), .bus_dir(bus_dir[1]),
        .wr_count(wr_count[1]), .rd_count(rd_count[1])
    );

    int            vecs = 0;
    int            errs = 0;
    int            s    = 0;
    int            n_wr [2];
    int            n_rd [2];
    logic [DW-1:0] wq [$];
    logic [DW-1:0] rq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s (inst %0d): observed %0h, expected %0h", tag, s, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ta();
        return (s == 0) ? 1 : 2;
    endfunction

    // Present a request in an IDLE cycle; returns in the following cycle
    task automatic accept(input logic w, input logic [DW-1:0] d);
        req_valid[s] = 1'b1;
        req_write[s] = w;
        req_wdata[s] = d;
        check("req_ready_at_accept", req_ready[s], 1);
        if (w) wq.push_back(d);
        tick();
        req_valid[s] = 1'b0;
    endtask

    task automatic do_write(input logic [DW-1:0] d, input bit turn);
        accept(1'b1, d);
        if (turn) begin
            for (int i = 0; i < ta(); i++) begin
                check("turn_wr_oe", bus_data_oe[s], 0);
                check("turn_wr_dir", bus_dir[s], 1);
                check("turn_wr_ready", req_ready[s], 0);
                tick();
            end
        end
        check("write_oe", bus_data_oe[s], 1);
        check("write_dir", bus_dir[s], 1);
        if (wq.size() == 0) check("write_queue_empty", 1, 0);
        else check("write_data", bus_data_o[s], wq.pop_front());
        n_wr[s]++;
        tick();
        check("post_wr_oe", bus_data_oe[s], 0);
        check("post_wr_dir", bus_dir[s], 1);
        check("post_wr_ready", req_ready[s], 1);
    endtask

    task automatic do_read(input logic [DW-1:0] d, input bit turn, input int hold);
        logic [DW-1:0] exp;
        bus_data_i[s] = d;
        rq.push_back(d);
        accept(1'b0, 8'h00);
        if (turn) begin
            for (int i = 0; i < ta(); i++) begin
                check("turn_rd_oe", bus_data_oe[s], 0);
                check("turn_rd_dir", bus_dir[s], 0);
                check("turn_rd_rspv", rsp_valid[s], 0);
                tick();
            end
        end
        check("capture_oe", bus_data_oe[s], 0);
        check("capture_dir", bus_dir[s], 0);
        check("capture_rspv", rsp_valid[s], 0);
        tick();
        bus_data_i[s] = ~d;
        check("resp_valid", rsp_valid[s], 1);
        exp = (rq.size() == 0) ? ~d : rq.pop_front();
        check("resp_rdata", rsp_rdata[s], exp);
        for (int i = 0; i < hold; i++) begin
            req_valid[s] = 1'b1;
            req_write[s] = 1'b1;
            tick();
            check("hold_valid", rsp_valid[s], 1);
            check("hold_rdata", rsp_rdata[s], exp);
            check("hold_ready", req_ready[s], 0);
        end
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        tick();
        rsp_ready[s] = 1'b0;
        n_rd[s]++;
        check("post_rsp_valid", rsp_valid[s], 0);
        check("post_rsp_ready", req_ready[s], 1);
    endtask

    task automatic check_stats();
`ifdef BIDIR_XFER_STATS_EN
        check("wr_count", wr_count[s], n_wr[s]);
        check("rd_count", rd_count[s], n_rd[s]);
`else
        check("wr_count", wr_count[s], 0);
        check("rd_count", rd_count[s], 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_wdata[i]  = '0;
            rsp_ready[i]  = 1'b0;
            bus_data_i[i] = '0;
            n_wr[i]       = 0;
            n_rd[i]       = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state on both instances
        for (int i = 0; i < 2; i++) begin
            s = i;
            check("rst_oe", bus_data_oe[s], 0);
            check("rst_dir", bus_dir[s], 0);
            check("rst_data_o", bus_data_o[s], 0);
            check("rst_rsp_valid", rsp_valid[s], 0);
            check("rst_rsp_rdata", rsp_rdata[s], 0);
            check("rst_req_ready", req_ready[s], 1);
            check_stats();
        end

        // Single write with one turnaround cycle, then back-to-back writes
        s = 0;
        do_write(8'hA5, 1'b1);
        do_write(8'h01, 1'b0);
        do_write(8'h02, 1'b0);

        // Dropped request without acceptance has no effect
        req_valid[s] = 1'b1;
        req_write[s] = 1'b0;
        #2;
        req_valid[s] = 1'b0;
        tick();
        check("drop_ready", req_ready[s], 1);
        check("drop_dir", bus_dir[s], 1);

        // Write then read with two turnaround cycles
        s = 1;
        do_write(8'h55, 1'b1);
        do_read(8'h3C, 1'b1, 0);

        // Read held off by the consumer for five cycles
        s = 0;
        do_read(8'hC7, 1'b1, 5);

        // Reset while driving a write
        accept(1'b1, 8'h9E);
        check("pre_rst_turn_dir", bus_dir[s], 1);
        tick();
        check("pre_rst_oe", bus_data_oe[s], 1);
        if (wq.size() == 0) check("pre_rst_queue_empty", 1, 0);
        else check("pre_rst_data", bus_data_o[s], wq.pop_front());
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_wr[i] = 0;
            n_rd[i] = 0;
        end
        check("mid_rst_oe", bus_data_oe[s], 0);
        check("mid_rst_dir", bus_dir[s], 0);
        check("mid_rst_rspv", rsp_valid[s], 0);
        check("mid_rst_data_o", bus_data_o[s], 0);
        check("mid_rst_ready", req_ready[s], 1);
        check_stats();
        do_read(8'h5A, 1'b0, 0);

        // Counter totals: three writes and two reads since reset
        do_write(8'h11, 1'b1);
        do_write(8'h22, 1'b0);
        do_write(8'h33, 1'b0);
        do_read(8'h66, 1'b1, 0);
        check_stats();
        s = 1;
        check_stats();

        s = 0;
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
